// File: rtl/aer_src_arbiter.sv
// rtl/aer_src_arbiter.sv - N-source AER arbiter: fixed-priority control events, round-robin neuron events
module aer_src_arbiter #(
  parameter int N_SRC       = 4,
  parameter int AER_WIDTH   = 10,
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_WIDTH   = 32,
  localparam int GW         = (N_SRC > 1) ? $clog2(N_SRC) : 1,
  localparam int IW         = AER_WIDTH - 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [N_SRC-1:0]                src_req,
  input  logic [N_SRC-1:0][AER_WIDTH-1:0] src_event,
  input  logic [N_SRC-1:0][IW-1:0]        src_idx,
  output logic [N_SRC-1:0]                src_ack,
  output logic                            out_req,
  output logic [AER_WIDTH-1:0]            out_event,
  output logic [IW-1:0]                   out_idx,
  input  logic                            out_ack,
  output logic                            busy,
  output logic [GW-1:0]                   grant_id,
  output logic [CNT_WIDTH-1:0]            evt_count,
  output logic                            err_timeout
);

  // Timeout counter only needs to reach TIMEOUT_CYC; it saturates there.
  localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t        state;
  logic [GW-1:0] rr_ptr;
  logic          grant_cls1;
  logic [TW-1:0] tmo_cnt;

  logic          cls1_hit;
  logic [GW-1:0] cls1_id;
  logic          rr_hit;
  logic [GW-1:0] rr_id;
  logic [GW-1:0] winner;
  logic          launch;
  logic [GW-1:0] rr_next;
  int            cand;

  // Class 1: lowest-index requester carrying a control (non-neuron) event type.
  // Class 2: first requester at or above rr_ptr, wrapping past the top index.
  always_comb begin
    cls1_hit = 1'b0;
    cls1_id  = '0;
    rr_hit   = 1'b0;
    rr_id    = '0;
    cand     = 0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (src_req[i] && (src_event[i][AER_WIDTH-1 -: 2] != 2'b00)) begin
        cls1_hit = 1'b1;
        cls1_id  = GW'(i);
      end
    end
    // Descending scan so the smallest offset from rr_ptr is written last and wins.
    for (int k = N_SRC - 1; k >= 0; k--) begin
      cand = int'(rr_ptr) + k;
      if (cand >= N_SRC) cand = cand - N_SRC;
      if (src_req[cand]) begin
        rr_hit = 1'b1;
        rr_id  = GW'(cand);
      end
    end
  end

  // Winner selection and launch qualification; a stale out_ack blocks a new launch.
  always_comb begin
    winner  = cls1_hit ? cls1_id : rr_id;
    launch  = (state == S_IDLE) && (cls1_hit || rr_hit) && !out_ack;
    rr_next = (grant_id == GW'(N_SRC - 1)) ? '0 : grant_id + GW'(1);
  end

  assign busy = (state != S_IDLE);

  // Transfer FSM: IDLE -> REQ (mapper handshake) -> ACK (source handshake) -> IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      rr_ptr      <= '0;
      grant_cls1  <= 1'b0;
      tmo_cnt     <= '0;
      src_ack     <= '0;
      out_req     <= 1'b0;
      out_event   <= '0;
      out_idx     <= '0;
      grant_id    <= '0;
      evt_count   <= '0;
      err_timeout <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (launch) begin
            out_event  <= src_event[winner];
            out_idx    <= src_idx[winner];
            grant_id   <= winner;
            grant_cls1 <= cls1_hit;
            out_req    <= 1'b1;
            tmo_cnt    <= '0;
            state      <= S_REQ;
          end
        end
        S_REQ: begin
          if (out_ack) begin
            out_req           <= 1'b0;
            src_ack[grant_id] <= 1'b1;
            state             <= S_ACK;
          end else if ((TIMEOUT_CYC != 0) && (tmo_cnt != TW'(TIMEOUT_CYC))) begin
            // Keep waiting after a timeout; the flag is only a sticky diagnostic.
            tmo_cnt <= tmo_cnt + TW'(1);
            if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) err_timeout <= 1'b1;
          end
        end
        S_ACK: begin
          if (!src_req[grant_id]) begin
            src_ack   <= '0;
            evt_count <= evt_count + CNT_WIDTH'(1);
            state     <= S_IDLE;
            // Control-event grants do not disturb neuron-event fairness.
            if (!grant_cls1) rr_ptr <= rr_next;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aer_src_arbiter.sv
// tb/tb_aer_src_arbiter.sv - directed self-checking bench for aer_src_arbiter
module tb_aer_src_arbiter;

  localparam int N  = 4;
  localparam int W  = 10;
  localparam int IW = 8;
  localparam int TO = 8;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic [N-1:0]        src_req = '0;
  logic [N-1:0][W-1:0] src_event = '0;
  logic [N-1:0][IW-1:0] src_idx = '0;
  logic [N-1:0]        src_ack;
  logic                out_req;
  logic [W-1:0]        out_event;
  logic [IW-1:0]       out_idx;
  logic                out_ack = 1'b0;
  logic                busy;
  logic [1:0]          grant_id;
  logic [31:0]         evt_count;
  logic                err_timeout;

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;

  aer_src_arbiter #(
    .N_SRC(N), .AER_WIDTH(W), .TIMEOUT_CYC(TO), .CNT_WIDTH(32)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .src_req(src_req), .src_event(src_event), .src_idx(src_idx), .src_ack(src_ack),
    .out_req(out_req), .out_event(out_event), .out_idx(out_idx), .out_ack(out_ack),
    .busy(busy), .grant_id(grant_id), .evt_count(evt_count), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // One complete transfer: mapper acks at once, granted source drops req on ack.
  task automatic xfer(input bit rereq, output bit ok, output int gid,
                      output logic [W-1:0] ev, output logic [IW-1:0] ix);
    int n;
    ok = 1'b0; gid = 0; ev = '0; ix = '0;
    n = 0;
    while (!out_req && n < 20) begin @(posedge clk); #1; n++; end
    if (out_req) begin
      gid = int'(grant_id); ev = out_event; ix = out_idx;
      out_ack = 1'b1;
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!src_ack[gid] && n < 20);
      if (src_ack[gid]) begin
        src_req[gid] = 1'b0;
        out_ack = 1'b0;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (src_ack[gid] && n < 20);
        if (!src_ack[gid]) begin
          exp_cnt++;
          if (rereq) src_req[gid] = 1'b1;
          ok = 1'b1;
        end
      end else begin
        out_ack = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    bit ok; int g; logic [W-1:0] ev; logic [IW-1:0] ix;
    int exp_ids[5] = '{0, 1, 2, 3, 0};
    for (int i = 0; i < N; i++) begin
      src_event[i] = {2'b00, IW'(8'h10 + i)};
      src_idx[i]   = IW'(8'hA0 + i);
    end
    src_req = 4'hF;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({out_req, src_ack, busy, err_timeout} !== 7'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b want=0", {out_req, src_ack, busy, err_timeout});
    end
    total++;
    if ({out_event, out_idx, grant_id, evt_count} !== '0) begin
      bad++; $display("FAIL reset_data ev=%h idx=%h gid=%0d cnt=%0d want all 0",
                      out_event, out_idx, grant_id, evt_count);
    end
    rst_n = 1'b1;
    exp_cnt = 0;
    for (int t = 0; t < 5; t++) begin
      xfer(t < 4, ok, g, ev, ix);
      total++;
      if (!ok || g !== exp_ids[t] || ix !== IW'(8'hA0 + exp_ids[t]) ||
          ev !== {2'b00, IW'(8'h10 + exp_ids[t])}) begin
        bad++; $display("FAIL reset_order t=%0d ok=%0d gid=%0d idx=%h ev=%h want gid=%0d",
                        t, ok, g, ix, ev, exp_ids[t]);
      end
    end
    src_req = '0;
    total++;
    if (evt_count !== 32'd5) begin
      bad++; $display("FAIL reset_count got=%0d want=5", evt_count);
    end
  endtask

  task automatic test_rr_pair();
    bit ok; int g; logic [W-1:0] ev; logic [IW-1:0] ix;
    src_event[2] = {2'b00, 8'h25}; src_idx[2] = 8'h5A;
    src_event[3] = {2'b00, 8'h3C}; src_idx[3] = 8'hC3;
    src_req[2] = 1'b1;
    xfer(1'b0, ok, g, ev, ix);
    total++;
    if (!ok || g !== 2) begin bad++; $display("FAIL rr_setup ok=%0d gid=%0d want 2", ok, g); end
    src_req[2] = 1'b1; src_req[3] = 1'b1;
    xfer(1'b0, ok, g, ev, ix);
    total++;
    if (!ok || g !== 3 || ix !== 8'hC3 || ev !== {2'b00, 8'h3C}) begin
      bad++; $display("FAIL rr_first gid=%0d idx=%h ev=%h want 3 c3 03c", g, ix, ev);
    end
    xfer(1'b0, ok, g, ev, ix);
    total++;
    if (!ok || g !== 2 || ix !== 8'h5A || ev !== {2'b00, 8'h25}) begin
      bad++; $display("FAIL rr_second gid=%0d idx=%h ev=%h want 2 5a 025", g, ix, ev);
    end
    total++;
    if (evt_count !== 32'(exp_cnt)) begin
      bad++; $display("FAIL rr_count got=%0d want=%0d", evt_count, exp_cnt);
    end
  endtask

  task automatic test_priority();
    bit ok; int g; logic [W-1:0] ev; logic [IW-1:0] ix;
    src_event[1] = {2'b00, 8'h11}; src_idx[1] = 8'h21;
    src_event[3] = {2'b10, 8'h13}; src_idx[3] = 8'h23;
    src_req[1] = 1'b1; src_req[3] = 1'b1;
    xfer(1'b0, ok, g, ev, ix);
    total++;
    if (!ok || g !== 3 || ev[W-1:W-2] !== 2'b10 || ix !== 8'h23) begin
      bad++; $display("FAIL prio_ctrl gid=%0d ev=%h idx=%h want 3 213 23", g, ev, ix);
    end
    xfer(1'b0, ok, g, ev, ix);
    total++;
    if (!ok || g !== 1 || ix !== 8'h21) begin
      bad++; $display("FAIL prio_next gid=%0d idx=%h want 1 21", g, ix);
    end
    // rr_ptr is now 2; a control grant must leave it at 2, so src2 beats src1
    src_event[2] = {2'b00, 8'h12}; src_idx[2] = 8'h22;
    src_req[1] = 1'b1; src_req[2] = 1'b1; src_req[3] = 1'b1;
    xfer(1'b0, ok, g, ev, ix);
    total++;
    if (!ok || g !== 3) begin bad++; $display("FAIL prio_ctrl2 gid=%0d want 3", g); end
    xfer(1'b0, ok, g, ev, ix);
    total++;
    if (!ok || g !== 2) begin bad++; $display("FAIL prio_rr_kept gid=%0d want 2", g); end
    xfer(1'b0, ok, g, ev, ix);
    total++;
    if (!ok || g !== 1) begin bad++; $display("FAIL prio_rr_last gid=%0d want 1", g); end
    // two control requesters: lowest index first
    src_event[0] = {2'b01, 8'h40}; src_idx[0] = 8'h40;
    src_event[2] = {2'b11, 8'h42}; src_idx[2] = 8'h42;
    src_req[0] = 1'b1; src_req[2] = 1'b1;
    xfer(1'b0, ok, g, ev, ix);
    total++;
    if (!ok || g !== 0 || ix !== 8'h40) begin bad++; $display("FAIL prio_low gid=%0d want 0", g); end
    xfer(1'b0, ok, g, ev, ix);
    total++;
    if (!ok || g !== 2 || ev !== {2'b11, 8'h42}) begin
      bad++; $display("FAIL prio_low2 gid=%0d ev=%h want 2 342", g, ev);
    end
    for (int i = 0; i < N; i++) src_event[i] = {2'b00, IW'(8'h50 + i)};
  endtask

  task automatic test_withdraw();
    bit ok; int g; logic [W-1:0] ev; logic [IW-1:0] ix;
    // rr_ptr is 2: src0 wins over src1 by wrap-around
    src_req[0] = 1'b1; src_req[1] = 1'b1;
    @(posedge clk); #1;
    total++;
    if (out_req !== 1'b1 || grant_id !== 2'd0 || busy !== 1'b1) begin
      bad++; $display("FAIL wd_launch req=%b gid=%0d busy=%b want 1 0 1", out_req, grant_id, busy);
    end
    src_req[1] = 1'b0; src_req[3] = 1'b1;
    xfer(1'b0, ok, g, ev, ix);
    total++;
    if (!ok || g !== 0) begin bad++; $display("FAIL wd_first gid=%0d want 0", g); end
    xfer(1'b0, ok, g, ev, ix);
    total++;
    if (!ok || g !== 3) begin bad++; $display("FAIL wd_skip gid=%0d want 3", g); end
  endtask

  task automatic test_ack_hold();
    bit ok; int g; int n; logic [W-1:0] ev; logic [IW-1:0] ix;
    src_idx[0] = 8'h33;
    src_req[0] = 1'b1;
    for (int t = 0; t < 2; t++) begin
      n = 0;
      while (!out_req && n < 20) begin @(posedge clk); #1; n++; end
      total++;
      if (out_req !== 1'b1) begin bad++; $display("FAIL hold_launch t=%0d req=%b want 1", t, out_req); end
      out_ack = 1'b1;
      @(posedge clk); #1;
      total++;
      if (src_ack !== 4'b0001 || out_req !== 1'b0) begin
        bad++; $display("FAIL hold_ack t=%0d ack=%b req=%b want 0001 0", t, src_ack, out_req);
      end
      src_req[0] = 1'b0;
      @(posedge clk); #1;
      exp_cnt++;
      total++;
      if (evt_count !== 32'(exp_cnt) || src_ack !== 4'b0) begin
        bad++; $display("FAIL hold_count t=%0d cnt=%0d ack=%b want %0d 0", t, evt_count, src_ack, exp_cnt);
      end
      src_req[0] = 1'b1;
      for (int h = 0; h < 3; h++) begin
        @(posedge clk); #1;
        total++;
        if (out_req !== 1'b0 || busy !== 1'b0) begin
          bad++; $display("FAIL hold_stall t=%0d h=%0d req=%b busy=%b want 0 0", t, h, out_req, busy);
        end
      end
      out_ack = 1'b0;
    end
    xfer(1'b0, ok, g, ev, ix);
    total++;
    if (!ok || g !== 0 || evt_count !== 32'(exp_cnt) || err_timeout !== 1'b0) begin
      bad++; $display("FAIL hold_final ok=%0d gid=%0d cnt=%0d err=%b want 1 0 %0d 0",
                      ok, g, evt_count, err_timeout, exp_cnt);
    end
  endtask

  task automatic test_timeout();
    bit ok; int g; int n; logic [W-1:0] ev; logic [IW-1:0] ix;
    src_req[1] = 1'b1;
    n = 0;
    while (!out_req && n < 20) begin @(posedge clk); #1; n++; end
    total++;
    if (out_req !== 1'b1) begin bad++; $display("FAIL to_launch req=%b want 1", out_req); end
    repeat (7) begin @(posedge clk); #1; end
    total++;
    if (err_timeout !== 1'b0) begin bad++; $display("FAIL to_early err=%b want 0 after 7 cycles", err_timeout); end
    @(posedge clk); #1;
    total++;
    if (err_timeout !== 1'b1 || out_req !== 1'b1) begin
      bad++; $display("FAIL to_set err=%b req=%b want 1 1 after 8 cycles", err_timeout, out_req);
    end
    repeat (5) begin @(posedge clk); #1; end
    total++;
    if (err_timeout !== 1'b1 || out_req !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL to_hold err=%b req=%b busy=%b want 1 1 1", err_timeout, out_req, busy);
    end
    xfer(1'b0, ok, g, ev, ix);
    total++;
    if (!ok || g !== 1 || err_timeout !== 1'b1) begin
      bad++; $display("FAIL to_sticky ok=%0d gid=%0d err=%b want 1 1 1", ok, g, err_timeout);
    end
  endtask

  task automatic test_reset_mid_and_sweep();
    bit ok; int g; int n; int badx; logic [W-1:0] ev; logic [IW-1:0] ix; logic [IW-1:0] idx;
    src_req[2] = 1'b1;
    n = 0;
    while (!out_req && n < 20) begin @(posedge clk); #1; n++; end
    out_ack = 1'b1;
    @(posedge clk); #1;
    total++;
    if (src_ack !== 4'b0100) begin bad++; $display("FAIL mid_ack ack=%b want 0100", src_ack); end
    rst_n = 1'b0;
    #1;
    total++;
    if (src_ack !== 4'b0 || out_req !== 1'b0 || busy !== 1'b0 || evt_count !== 32'd0 || err_timeout !== 1'b0) begin
      bad++; $display("FAIL mid_reset ack=%b req=%b busy=%b cnt=%0d err=%b want all 0",
                      src_ack, out_req, busy, evt_count, err_timeout);
    end
    out_ack = 1'b0;
    src_req = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_cnt = 0;
    badx = 0;
    for (int c = 0; c < 3; c++) begin
      for (int y = 0; y < 8; y++) begin
        for (int x = 0; x < 8; x++) begin
          idx = {2'(c), 3'(y), 3'(x)};
          src_event[0] = {2'b00, idx};
          src_idx[0]   = idx;
          src_req[0]   = 1'b1;
          xfer(1'b0, ok, g, ev, ix);
          total++;
          if (!ok || g !== 0 || ix !== idx || ev !== {2'b00, idx}) begin
            bad++; badx++;
            if (badx < 5) $display("FAIL sweep c=%0d y=%0d x=%0d ok=%0d gid=%0d idx=%h want %h",
                                   c, y, x, ok, g, ix, idx);
          end
        end
      end
    end
    total++;
    if (evt_count !== 32'd192) begin bad++; $display("FAIL sweep_count got=%0d want=192", evt_count); end
  endtask

  initial begin
    test_reset();
    test_rr_pair();
    test_priority();
    test_withdraw();
    test_ack_hold();
    test_timeout();
    test_reset_mid_and_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
